// File: rtl/coll_pair_sched_if.sv
// Detector operand bus and hit stream between coll_pair_sched (master) and its
// detector / collision-response consumer (slave).
interface coll_pair_sched_if #(
    parameter int IDX_W = 3
);
    logic [15:0]      det_x1, det_y1, det_vx1, det_vy1;
    logic [15:0]      det_x2, det_y2, det_vx2, det_vy2;
    logic [31:0]      det_r;
    logic             det_trial;
    logic             hit_valid;
    logic             hit_ready;
    logic [IDX_W-1:0] hit_i;
    logic [IDX_W-1:0] hit_j;

    modport master (
        output det_x1, det_y1, det_vx1, det_vy1,
        output det_x2, det_y2, det_vx2, det_vy2,
        output det_r, hit_valid, hit_i, hit_j,
        input  det_trial, hit_ready
    );

    modport slave (
        input  det_x1, det_y1, det_vx1, det_vy1,
        input  det_x2, det_y2, det_vx2, det_vy2,
        input  det_r, hit_valid, hit_i, hit_j,
        output det_trial, hit_ready
    );
endinterface

// File: rtl/coll_pair_sched.sv
// Walks every unordered object pair (i<j), feeds the collision detector and streams hits.
// Optional macro COLL_SCHED_HIT_FIFO_EN: 4-entry hit FIFO instead of a PUSH handshake stall.
module coll_pair_sched #(
    parameter int N_OBJ = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [15:0]          wr_x,
    input  logic [15:0]          wr_y,
    input  logic [15:0]          wr_vx,
    input  logic [15:0]          wr_vy,
    input  logic                 start,
    input  logic [31:0]          r_thresh,
    coll_pair_sched_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     hit_count
);
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] vx;
        logic [15:0] vy;
    } obj_t;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_SAMPLE, S_PUSH, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_OBJ - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_OBJ - 2);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
    logic [31:0]      r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    obj_t             det1_q, det1_d, det2_q, det2_d;
    obj_t             tbl_rd [N_OBJ];
    obj_t             wr_obj;
    logic             tbl_we;
    logic             adv;

    assign wr_obj = {wr_x, wr_y, wr_vx, wr_vy};
    assign tbl_we = wr_en && (state_q == S_IDLE);

    // Register-based table: every entry must clear on reset. Out-of-range indices match no entry.
    genvar gi;
    for (gi = 0; gi < N_OBJ; gi++) begin : g_tbl
        obj_t ent_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                ent_q <= '0;
            else if (tbl_we && wr_idx == IDX_W'(gi))
                ent_q <= wr_obj;
        end
        assign tbl_rd[gi] = ent_q;
    end

`ifdef COLL_SCHED_HIT_FIFO_EN
    localparam int FIFO_D = 4;
    logic [2*IDX_W-1:0] fifo_q [FIFO_D];
    logic [1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [2:0]         fcnt_q, fcnt_d;
    logic               fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (fcnt_q == 3'd4);
    assign fifo_empty = (fcnt_q == 3'd0);
    assign pop        = !fifo_empty && bus.hit_ready;

    always_comb begin
        wp_d   = push ? wp_q + 2'd1 : wp_q;
        rp_d   = pop  ? rp_q + 2'd1 : rp_q;
        fcnt_d = fcnt_q + 3'(push) - 3'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_D; k++) fifo_q[k] <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) fifo_q[wp_q] <= {i_q, j_q};
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign bus.hit_valid            = !fifo_empty;
    assign {bus.hit_i, bus.hit_j}   = fifo_q[rp_q];
`else
    logic [IDX_W-1:0] hit_i_q, hit_i_d, hit_j_q, hit_j_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_i_q <= '0;
            hit_j_q <= '0;
        end else begin
            hit_i_q <= hit_i_d;
            hit_j_q <= hit_j_d;
        end
    end

    assign bus.hit_valid = (state_q == S_PUSH);
    assign bus.hit_i     = hit_i_q;
    assign bus.hit_j     = hit_j_q;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        det1_d  = det1_q;
        det2_d  = det2_q;
        adv     = 1'b0;
`ifdef COLL_SCHED_HIT_FIFO_EN
        push    = 1'b0;
`else
        hit_i_d = hit_i_q;
        hit_j_d = hit_j_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = r_thresh;
                    i_d     = '0;
                    j_d     = IDX_W'(1);
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                det1_d  = tbl_rd[i_q];
                det2_d  = tbl_rd[j_q];
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
`ifdef COLL_SCHED_HIT_FIFO_EN
                if (!(bus.det_trial && fifo_full)) begin
                    adv = 1'b1;
                    if (bus.det_trial) begin
                        push  = 1'b1;
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    end
                end
`else
                if (bus.det_trial) begin
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    hit_i_d = i_q;
                    hit_j_d = j_q;
                    state_d = S_PUSH;
                end else begin
                    adv = 1'b1;
                end
`endif
            end
            S_PUSH: begin
`ifdef COLL_SCHED_HIT_FIFO_EN
                // With the FIFO, PUSH only waits for the final drain before DONE.
                if (fifo_empty) state_d = S_DONE;
`else
                if (bus.hit_ready) adv = 1'b1;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (j_q != LAST_J) begin
                j_d     = j_q + 1'b1;
                state_d = S_ISSUE;
            end else if (i_q != LAST_I) begin
                i_d     = i_q + 1'b1;
                j_d     = i_q + IDX_W'(2);
                state_d = S_ISSUE;
            end else begin
`ifdef COLL_SCHED_HIT_FIFO_EN
                state_d = (fifo_empty && !push) ? S_DONE : S_PUSH;
`else
                state_d = S_DONE;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            det1_q  <= '0;
            det2_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            det1_q  <= det1_d;
            det2_q  <= det2_d;
        end
    end

    assign bus.det_x1  = det1_q.x;
    assign bus.det_y1  = det1_q.y;
    assign bus.det_vx1 = det1_q.vx;
    assign bus.det_vy1 = det1_q.vy;
    assign bus.det_x2  = det2_q.x;
    assign bus.det_y2  = det2_q.y;
    assign bus.det_vx2 = det2_q.vx;
    assign bus.det_vy2 = det2_q.vy;
    assign bus.det_r   = r_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign hit_count   = cnt_q;
endmodule

// File: doc/coll_pair_sched.md
# coll_pair_sched

Pair scheduler and initiator for the collision detector. Holds a table of `N_OBJ` object states (position and velocity, 16 bits each) and, on `start`, walks every unordered pair (i<j). For each pair it drives registered operands to the detector, samples the detector's `det_trial` result, and emits colliding pair indices on a valid/ready stream. It sits between the object-state loader and the collision-response logic, with the detector instance hung off its `det_*` ports.

## Interface
- `N_OBJ`, 8: number of objects; legal range 2..16.
- `IDX_W`, 3: object index width; ceil(log2(N_OBJ)), minimum 1.
- `CNT_W`, 8: width of the hit counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: write one table entry this cycle; ignored while `busy`.
- `wr_idx` in IDX_W: entry index; writes with `wr_idx` ≥ N_OBJ are dropped.
- `wr_x`, `wr_y`, `wr_vx`, `wr_vy` in 16 each: entry data.
- `start` in 1: begin a scan; sampled only in IDLE.
- `r_thresh` in 32: threshold R; captured on the `start` cycle.
- `det_x1`, `det_y1`, `det_vx1`, `det_vy1` out 16 each: object i state, registered.
- `det_x2`, `det_y2`, `det_vx2`, `det_vy2` out 16 each: object j state, registered.
- `det_r` out 32: captured R.
- `det_trial` in 1: combinational detector result for the current `det_*` operands.
- `hit_valid` out 1, `hit_ready` in 1: hit stream handshake.
- `hit_i`, `hit_j` out IDX_W each: colliding pair, with i<j.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at the end of a scan.
- `hit_count` out CNT_W: hits in the last or current scan; saturates at all-ones.

## Operation
- FSM states: IDLE, ISSUE, SAMPLE, PUSH, DONE.
- IDLE:
  - Table writes are accepted.
  - On `start`: capture `r_thresh`, set i=0 and j=1, clear `hit_count`, then go to ISSUE.
- ISSUE: load `det_*` from table[i] and table[j], then go to SAMPLE.
- SAMPLE: sample `det_trial`.
  - If 1: increment `hit_count` (saturating), then go to PUSH.
  - If 0: advance.
- PUSH:
  - Drive `hit_valid`=1 with `hit_i`=i and `hit_j`=j.
  - Hold until `hit_valid && hit_ready`, then advance.
- Advance rule:
  - If j < N_OBJ-1: j++.
  - Otherwise, if i < N_OBJ-2: i++ and j=i+1.
  - Otherwise: the pair is final; go to DONE.
  - After a non-final advance, go to ISSUE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE. The table is frozen while `busy`.
- `start` asserted while `busy` is ignored.
- `hit_i`, `hit_j`, `det_*` and `det_r` hold their last values when not updated.
- Reset values:
  - State IDLE.
  - All table entries, `det_*`, `det_r`, `hit_i`, `hit_j` and `hit_count` are 0.
  - `hit_valid`, `busy` and `done` are 0.
- Reset mid-scan aborts immediately. No `done` pulse is produced and any pending hit is lost.

## Timing
- `start` sampled at edge k: `busy` rises in cycle k+1 (ISSUE). `det_*` are valid from cycle k+2 (SAMPLE).
- Each pair costs 2 cycles without a hit, or 3+s cycles with a hit, where s is the number of stall cycles with `hit_ready`=0.
- Zero-hit scan: `done` is high in cycle k+1+2P, where P=N_OBJ(N_OBJ-1)/2. For N_OBJ=8 this is k+57.
- `hit_valid` rises in the cycle after SAMPLE. It must not drop, and `hit_i`/`hit_j` must not change, until the handshake completes.
- A table write and `start` in the same IDLE cycle: the write lands first, so the scan uses the new entry.

## Configuration
- `COLL_SCHED_HIT_FIFO_EN` defined: hits go into a 4-entry FIFO that drives `hit_*`.
  - SAMPLE with a hit pushes to the FIFO and advances without PUSH; the per-pair cost is 2 cycles.
  - The FSM stalls in SAMPLE only when the FIFO is full.
  - DONE is entered only after the final pair and once the FIFO is empty.
  - Reset empties the FIFO.
- `COLL_SCHED_HIT_FIFO_EN` undefined: PUSH-state behaviour as described above. No FIFO storage exists.

## Test plan
The bench uses a behavioural detector: `trial` = (|r|²|v|² − (r·v)²) < R·|v|².
- Zero-hit scan: N_OBJ=8 with all objects far apart and stationary, `start` at k -> 28 SAMPLE cycles, no `hit_valid`, `done` pulse at k+57, `hit_count`=0.
- Single hit: obj0 at (0,0) with v(1,0), obj1 at (10,0) with v(0xFFFF,0), R=4, all others distant -> one hit with `hit_i`=0 and `hit_j`=1, `hit_count`=1.
- Backpressure: same stimulus with `hit_ready` held low for 5 cycles -> `hit_valid` and indices stable throughout, and `done` arrives 5 cycles later than with no stall.
- Busy lockout: `wr_en` and `start` pulsed mid-scan -> table unchanged and scan uninterrupted. A second scan reproduces the same hits.
- Reset mid-scan: `rst_n` low during PUSH -> all outputs are 0 at once, and the table reads zero on the next scan.
- FIFO (macro defined): 5 hits with `hit_ready`=0 -> stall after the 4th hit, all 5 delivered in order once `hit_ready`=1, and `done` follows the drain.
